sti_cmd_scheduler: RTL and testbench
====================================

STI_CMD_SCHEDULER -- requirements
Module: sti_cmd_scheduler

Interface
REQ-001 SHALL provide ports: clk  in  1  system clock, single domain.
REQ-002 SHALL provide: reset  in  1  asynchronous, active-low reset (reset=0 resets).
REQ-003 SHALL provide: c0_valid, c1_valid  in  1 each  requester 0/1 command valid.
REQ-004 SHALL provide: c0_cmd, c1_cmd  in  21 each  {data[15:0], length[1:0], fill, msb, low}, MSB first.
REQ-005 SHALL provide: c0_ready, c1_ready  out  1 each  command accepted when valid&ready.
REQ-006 SHALL provide: end_req  in  1  request to close the stream with pi_end.
REQ-007 SHALL provide: so_valid  in  1  serial-valid from the STI engine.
REQ-008 SHALL provide: load  out  1  one-cycle load strobe to the STI engine.
REQ-009 SHALL provide: pi_data 16, pi_length 2, pi_fill 1, pi_msb 1, pi_low 1  out  fields of the issued command.
REQ-010 SHALL provide: pi_end  out  1, busy  out  1, done  out  1, err  out  1, frame_cnt  out  8.

Function
REQ-011 SHALL implement states IDLE, LOAD, WAIT_V, SHIFT, GAP, END, DONE.
REQ-012 IDLE: only the granted requester's ready SHALL be 1; on valid&ready, latch cmd and go to LOAD next cycle.
REQ-013 Grant: single valid wins; both valid -> the requester not granted last; after reset requester 0 has priority.
REQ-014 LOAD: load=1 for exactly one cycle with pi_* equal to latched fields; then WAIT_V.
REQ-015 pi_* SHALL hold latched values from LOAD until the next accept; reset value 0.
REQ-016 WAIT_V: so_valid=1 -> SHIFT; 64 cycles without so_valid -> err=1 (sticky), go to GAP.
REQ-017 SHIFT: count cycles with so_valid=1 (6-bit); so_valid=0 -> GAP.
REQ-018 GAP: exactly one cycle, no ready asserted; frame_cnt increments (saturates at 255); then IDLE.
REQ-019 IDLE with end_req=1 and neither valid -> END; a pending command SHALL take precedence over end_req.
REQ-020 END: pi_end=1 for exactly one cycle; then DONE.
REQ-021 DONE: done=1, both ready=0, all inputs ignored until reset.
REQ-022 busy SHALL be 1 in LOAD, WAIT_V, SHIFT, GAP, END; 0 in IDLE and DONE.
REQ-023 end_req arriving in any non-IDLE state SHALL be registered and honoured at the next IDLE with no valid.

Reset
REQ-024 On reset=0: state IDLE; load, pi_*, pi_end, busy, done, err, frame_cnt, ready = 0; grant pointer to requester 0.
REQ-025 Reset mid-frame SHALL abort immediately; no load or pi_end pulse SHALL follow deassertion without a new command/end_req.

Configuration
REQ-026 Macro STI_SCHED_BITCHK_EN defined: on SHIFT exit, bit count SHALL equal 8,16,24,32 for length 0..3; mismatch sets err=1 (sticky).
REQ-027 STI_SCHED_BITCHK_EN undefined: no bit-count comparison; err driven only by WAIT_V timeout (REQ-016).

Verification
REQ-028 c0_valid, cmd data=16'hA5C3 length=1 -> c0_ready 1 cycle, load 1 cycle next cycle with pi_data=A5C3, pi_length=1; 16-cycle so_valid -> frame_cnt=1, err=0.
REQ-029 c0_valid and c1_valid held together for 4 frames -> grants alternate 0,1,0,1.
REQ-030 Command issued, so_valid never rises -> err=1 at 64th WAIT_V cycle; back to IDLE 2 cycles later.
REQ-031 BITCHK_EN, length=2, so_valid 23 cycles -> err=1; without macro -> err=0.
REQ-032 end_req while SHIFT with c1_valid pending -> c1 frame completes first, then pi_end 1 cycle, done=1, later c0_valid not accepted.
REQ-033 reset=0 asserted in SHIFT -> all outputs 0 same cycle; frame_cnt=0 after release.

Source files
------------

// File: rtl/sti_cmd_scheduler.sv
// sti_cmd_scheduler: two-requester command scheduler feeding an STI serializer engine.
// Define STI_SCHED_BITCHK_EN to flag frames whose serial bit count disagrees with the command length.
module sti_cmd_scheduler (
  input  logic        clk,
  input  logic        reset,
  input  logic        c0_valid,
  input  logic        c1_valid,
  input  logic [20:0] c0_cmd,
  input  logic [20:0] c1_cmd,
  output logic        c0_ready,
  output logic        c1_ready,
  input  logic        end_req,
  input  logic        so_valid,
  output logic        load,
  output logic [15:0] pi_data,
  output logic [1:0]  pi_length,
  output logic        pi_fill,
  output logic        pi_msb,
  output logic        pi_low,
  output logic        pi_end,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [7:0]  frame_cnt
);
  typedef enum logic [2:0] {IDLE, LOAD, WAIT_V, SHIFT, GAP, END, DONE} state_t;
  state_t      state_q, state_d;
  logic        prio_q, prio_d;
  logic        end_pend_q, end_pend_d;
  logic [20:0] cmd_q, cmd_d;
  logic [5:0]  wcnt_q, wcnt_d;
  logic [5:0]  bcnt_q, bcnt_d;
  logic        err_q, err_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        idle, gsel, accept, bit_err;
  // Grant selection, handshake and state-decoded outputs; ready is masked while reset is held
  always_comb begin
    idle      = state_q == IDLE;
    gsel      = (c0_valid & c1_valid) ? prio_q : c1_valid;
    c0_ready  = reset & idle & c0_valid & ~gsel;
    c1_ready  = reset & idle & c1_valid & gsel;
    accept    = c0_ready | c1_ready;
    load      = state_q == LOAD;
    pi_end    = state_q == END;
    done      = state_q == DONE;
    busy      = ~idle & ~done;
    pi_data   = cmd_q[20:5];
    pi_length = cmd_q[4:3];
    pi_fill   = cmd_q[2];
    pi_msb    = cmd_q[1];
    pi_low    = cmd_q[0];
    err       = err_q;
    frame_cnt = cnt_q;
`ifdef STI_SCHED_BITCHK_EN
    bit_err   = bcnt_q != {{1'b0, cmd_q[4:3]} + 3'd1, 3'b000};
`else
    bit_err   = 1'b0;
`endif
  end
  // Next-state logic; end requests are remembered until an idle cycle with no command pending
  always_comb begin
    state_d    = state_q;
    prio_d     = prio_q;
    end_pend_d = end_pend_q | end_req;
    cmd_d      = cmd_q;
    wcnt_d     = wcnt_q;
    bcnt_d     = bcnt_q;
    err_d      = err_q;
    cnt_d      = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = LOAD;
          cmd_d   = gsel ? c1_cmd : c0_cmd;
          prio_d  = ~gsel;
        end else if (end_pend_d) begin
          state_d    = END;
          end_pend_d = 1'b0;
        end
      end
      LOAD: begin
        state_d = WAIT_V;
        wcnt_d  = '0;
      end
      WAIT_V: begin
        if (so_valid) begin
          state_d = SHIFT;
          bcnt_d  = 6'd1;
        end else if (wcnt_q == 6'd63) begin
          state_d = GAP;
          err_d   = 1'b1;
        end else begin
          wcnt_d = wcnt_q + 6'd1;
        end
      end
      SHIFT: begin
        if (so_valid) begin
          bcnt_d = bcnt_q + 6'd1;
        end else begin
          state_d = GAP;
          err_d   = err_q | bit_err;
        end
      end
      GAP: begin
        state_d = IDLE;
        cnt_d   = cnt_q + {7'd0, cnt_q != 8'hFF};
      end
      END:     state_d = DONE;
      default: state_d = state_q;
    endcase
  end
  // State and datapath registers, cleared asynchronously so a reset aborts any frame at once
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      prio_q     <= 1'b0;
      end_pend_q <= 1'b0;
      cmd_q      <= '0;
      wcnt_q     <= '0;
      bcnt_q     <= '0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      prio_q     <= prio_d;
      end_pend_q <= end_pend_d;
      cmd_q      <= cmd_d;
      wcnt_q     <= wcnt_d;
      bcnt_q     <= bcnt_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
    end
  end
endmodule

// File: tb/tb_sti_cmd_scheduler.sv
// tb_sti_cmd_scheduler: randomized self-checking bench with a frame-level reference model.
module tb_sti_cmd_scheduler;
  logic        clk = 0, reset = 0;
  logic        c0_valid = 0, c1_valid = 0, end_req = 0, so_valid = 0;
  logic [20:0] c0_cmd = 0, c1_cmd = 0;
  logic        c0_ready, c1_ready, load, pi_fill, pi_msb, pi_low, pi_end, busy, done, err;
  logic [15:0] pi_data;
  logic [1:0]  pi_length;
  logic [7:0]  frame_cnt;
  int          checks = 0, passed = 0;
  int          m_last, m_cnt;
  logic        m_err;

  sti_cmd_scheduler dut (
    .clk(clk), .reset(reset), .c0_valid(c0_valid), .c1_valid(c1_valid),
    .c0_cmd(c0_cmd), .c1_cmd(c1_cmd), .c0_ready(c0_ready), .c1_ready(c1_ready),
    .end_req(end_req), .so_valid(so_valid), .load(load), .pi_data(pi_data),
    .pi_length(pi_length), .pi_fill(pi_fill), .pi_msb(pi_msb), .pi_low(pi_low),
    .pi_end(pi_end), .busy(busy), .done(done), .err(err), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  task step();
    @(posedge clk);
    #2;
  endtask

  task do_reset();
    reset = 0; c0_valid = 0; c1_valid = 0; end_req = 0; so_valid = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1;
    m_last = -1; m_cnt = 0; m_err = 0;
    step();
  endtask

  function automatic logic [20:0] mk_cmd(input logic [15:0] d, input logic [1:0] l, input logic [2:0] f);
    return {d, l, f};
  endfunction

  task accept(input logic v0, input logic v1, input logic [20:0] k0, input logic [20:0] k1, output int g);
    logic [20:0] kg;
    c0_cmd = k0; c1_cmd = k1; c0_valid = v0; c1_valid = v1;
    #1;
    g = (v0 && v1) ? (m_last == 0 ? 1 : 0) : (v1 ? 1 : 0);
    checks++; if (c0_ready !== (g == 0)) $display("FAIL c0_ready_idle: got %b want %b", c0_ready, g == 0); else passed++;
    checks++; if (c1_ready !== (g == 1)) $display("FAIL c1_ready_idle: got %b want %b", c1_ready, g == 1); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL busy_idle: got %b want 0", busy); else passed++;
    step();
    c0_valid = 0; c1_valid = 0;
    m_last = g;
    kg = g ? k1 : k0;
    #1;
    checks++; if (load !== 1'b1) $display("FAIL load_pulse: got %b want 1", load); else passed++;
    checks++; if ({pi_data, pi_length, pi_fill, pi_msb, pi_low} !== kg) $display("FAIL pi_fields: got %h want %h", {pi_data, pi_length, pi_fill, pi_msb, pi_low}, kg); else passed++;
    checks++; if ({c0_ready, c1_ready} !== 2'b00) $display("FAIL ready_in_load: got %b want 00", {c0_ready, c1_ready}); else passed++;
  endtask

  task finish(input int delay, input int nbits, input logic [1:0] len);
    so_valid = 0;
    step();
    checks++; if (load !== 1'b0) $display("FAIL load_one_cycle: got %b want 0", load); else passed++;
    repeat (delay) step();
    so_valid = 1;
    repeat (nbits) step();
    so_valid = 0;
    step();
    checks++; if (busy !== 1'b1) $display("FAIL busy_gap: got %b want 1", busy); else passed++;
    m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
`ifdef STI_SCHED_BITCHK_EN
    if (nbits != 8 * (int'(len) + 1)) m_err = 1;
`endif
    step();
    checks++; if (busy !== 1'b0) $display("FAIL busy_after_gap: got %b want 0", busy); else passed++;
    checks++; if (frame_cnt !== m_cnt[7:0]) $display("FAIL frame_cnt: got %0d want %0d", frame_cnt, m_cnt); else passed++;
    checks++; if (err !== m_err) $display("FAIL err_frame: got %b want %b", err, m_err); else passed++;
  endtask

  task test_reset();
    reset = 0; c0_valid = 1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if ({c0_ready, c1_ready, load, pi_data, pi_length, pi_fill, pi_msb, pi_low, pi_end, busy, done, err, frame_cnt} !== '0)
      $display("FAIL reset_outputs: got %h want 0", {c0_ready, c1_ready, load, pi_data, pi_length, pi_fill, pi_msb, pi_low, pi_end, busy, done, err, frame_cnt}); else passed++;
    do_reset();
  endtask

  task test_basic();
    int g;
    do_reset();
    accept(1, 0, mk_cmd(16'hA5C3, 2'd1, 3'b010), '0, g);
    checks++; if (pi_data !== 16'hA5C3 || pi_length !== 2'd1) $display("FAIL basic_pi: got %h/%0d want a5c3/1", pi_data, pi_length); else passed++;
    finish(0, 16, 2'd1);
    checks++; if (frame_cnt !== 8'd1 || err !== 1'b0) $display("FAIL basic_done: got cnt %0d err %b want 1/0", frame_cnt, err); else passed++;
  endtask

  task test_alternate();
    int g;
    logic [1:0] l;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      l = 2'($urandom_range(0, 3));
      c0_valid = 1; c1_valid = 1;
      #1;
      checks++; if (c1_ready !== (i % 2 == 1)) $display("FAIL alternate_grant%0d: got c1_ready %b want %b", i, c1_ready, i % 2 == 1); else passed++;
      accept(1, 1, mk_cmd(16'($urandom), l, 3'($urandom)), mk_cmd(16'($urandom), l, 3'($urandom)), g);
      finish(1, 8 * (int'(l) + 1), l);
    end
  endtask

  task test_random();
    int g, nb;
    logic [1:0] v, l0, l1;
    logic [20:0] k0, k1;
    do_reset();
    for (int i = 0; i < 30; i++) begin
      v = 2'($urandom_range(1, 3));
      l0 = 2'($urandom); l1 = 2'($urandom);
      k0 = mk_cmd(16'($urandom), l0, 3'($urandom));
      k1 = mk_cmd(16'($urandom), l1, 3'($urandom));
      accept(v[0], v[1], k0, k1, g);
      nb = ($urandom_range(0, 1) == 1) ? 8 * (int'(g ? l1 : l0) + 1) : int'($urandom_range(1, 40));
      finish(int'($urandom_range(0, 5)), nb, g ? l1 : l0);
    end
  endtask

  task test_bitchk();
    int g;
    logic e;
    do_reset();
    accept(1, 0, mk_cmd(16'h1234, 2'd2, 3'b101), '0, g);
    finish(2, 23, 2'd2);
`ifdef STI_SCHED_BITCHK_EN
    e = 1'b1;
`else
    e = 1'b0;
`endif
    checks++; if (err !== e) $display("FAIL bitchk_err: got %b want %b", err, e); else passed++;
  endtask

  task test_timeout();
    int g;
    do_reset();
    accept(0, 1, '0, mk_cmd(16'hBEEF, 2'd0, 3'b000), g);
    so_valid = 0;
    repeat (63) step();
    checks++; if (err !== 1'b0 || busy !== 1'b1) $display("FAIL timeout_63: got err %b busy %b want 0/1", err, busy); else passed++;
    step();
    checks++; if (busy !== 1'b1) $display("FAIL timeout_64_busy: got %b want 1", busy); else passed++;
    step();
    checks++; if (err !== 1'b1 || busy !== 1'b1) $display("FAIL timeout_gap: got err %b busy %b want 1/1", err, busy); else passed++;
    step();
    checks++; if (busy !== 1'b0 || err !== 1'b1 || frame_cnt !== 8'd1) $display("FAIL timeout_idle: got busy %b err %b cnt %0d want 0/1/1", busy, err, frame_cnt); else passed++;
    m_err = 1; m_cnt = 1;
  endtask

  task test_saturate();
    int g;
    do_reset();
    for (int i = 0; i < 258; i++) begin
      accept(1, 0, mk_cmd(16'(i), 2'd0, 3'b111), '0, g);
      finish(0, 8, 2'd0);
    end
    checks++; if (frame_cnt !== 8'd255) $display("FAIL frame_cnt_sat: got %0d want 255", frame_cnt); else passed++;
  endtask

  task test_reset_mid();
    int g;
    do_reset();
    accept(1, 0, mk_cmd(16'h0F0F, 2'd0, 3'b001), '0, g);
    finish(0, 8, 2'd0);
    accept(1, 0, mk_cmd(16'hF0F0, 2'd3, 3'b110), '0, g);
    so_valid = 1;
    repeat (3) step();
    c0_valid = 1;
    reset = 0;
    #1;
    checks++; if ({c0_ready, c1_ready, load, pi_data, pi_length, pi_fill, pi_msb, pi_low, pi_end, busy, done, err, frame_cnt} !== '0)
      $display("FAIL reset_mid_outputs: got %h want 0", {c0_ready, c1_ready, load, pi_data, pi_length, pi_fill, pi_msb, pi_low, pi_end, busy, done, err, frame_cnt}); else passed++;
    @(negedge clk);
    c0_valid = 0; so_valid = 0;
    reset = 1;
    m_last = -1; m_cnt = 0; m_err = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if ({load, pi_end, busy} !== 3'b000) $display("FAIL post_reset_quiet%0d: got %b want 000", i, {load, pi_end, busy}); else passed++;
    end
    checks++; if (frame_cnt !== 8'd0) $display("FAIL post_reset_cnt: got %0d want 0", frame_cnt); else passed++;
  endtask

  task test_end();
    int g;
    do_reset();
    accept(1, 0, mk_cmd(16'h5555, 2'd0, 3'b000), '0, g);
    so_valid = 0;
    step();
    so_valid = 1;
    for (int i = 0; i < 8; i++) begin
      end_req = (i == 3);
      step();
    end
    end_req = 0; so_valid = 0;
    c1_valid = 1; c1_cmd = mk_cmd(16'hAAAA, 2'd0, 3'b011);
    step();
    #1;
    checks++; if ({c0_ready, c1_ready} !== 2'b00) $display("FAIL gap_no_ready: got %b want 00", {c0_ready, c1_ready}); else passed++;
    m_cnt = m_cnt + 1;
    step();
    checks++; if (pi_end !== 1'b0) $display("FAIL end_deferred: got %b want 0", pi_end); else passed++;
    accept(0, 1, '0, mk_cmd(16'hAAAA, 2'd0, 3'b011), g);
    finish(0, 8, 2'd0);
    checks++; if (pi_end !== 1'b0 || done !== 1'b0) $display("FAIL end_idle: got pi_end %b done %b want 0/0", pi_end, done); else passed++;
    step();
    checks++; if (pi_end !== 1'b1 || busy !== 1'b1) $display("FAIL end_pulse: got pi_end %b busy %b want 1/1", pi_end, busy); else passed++;
    step();
    checks++; if (pi_end !== 1'b0 || done !== 1'b1 || busy !== 1'b0) $display("FAIL done_state: got pi_end %b done %b busy %b want 0/1/0", pi_end, done, busy); else passed++;
    c0_valid = 1;
    #1;
    checks++; if (c0_ready !== 1'b0) $display("FAIL done_ignores: got c0_ready %b want 0", c0_ready); else passed++;
    step();
    checks++; if (load !== 1'b0 || done !== 1'b1) $display("FAIL done_sticky: got load %b done %b want 0/1", load, done); else passed++;
    c0_valid = 0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_alternate();
    test_random();
    test_bitchk();
    test_timeout();
    test_saturate();
    test_reset_mid();
    test_end();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
